// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter sharing one slave between N_MASTER masters
// Grants are held for the whole cyc; a per-strobe watchdog aborts stalled slaves with err.
module wb_rr_arbiter #(
    parameter int N_MASTER = 2,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_MASTER-1:0]    m_cyc_i,
    input  logic [N_MASTER-1:0]    m_stb_i,
    input  logic [N_MASTER-1:0]    m_we_i,
    input  logic [32*N_MASTER-1:0] m_adr_i,
    input  logic [32*N_MASTER-1:0] m_dat_i,
    input  logic [4*N_MASTER-1:0]  m_sel_i,
    output logic [31:0]            m_dat_o,
    output logic [N_MASTER-1:0]    m_ack_o,
    output logic [N_MASTER-1:0]    m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    output logic [3:0]             s_sel_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [N_MASTER-1:0]    grant_o
);
    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTER - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gnt, gnt_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] scan_idx;
    logic             found;
    logic             gnt_cyc;
    logic             gnt_stb;

    logic [31:0] adr_arr [N_MASTER];
    logic [31:0] dat_arr [N_MASTER];
    logic [3:0]  sel_arr [N_MASTER];

    always_comb begin
        for (int k = 0; k < N_MASTER; k++) begin
            adr_arr[k] = m_adr_i[32*k +: 32];
            dat_arr[k] = m_dat_i[32*k +: 32];
            sel_arr[k] = m_sel_i[4*k +: 4];
        end
    end

    assign gnt_cyc = m_cyc_i[gnt];
    assign gnt_stb = m_stb_i[gnt];
    assign m_dat_o = s_dat_i;

    // Scan from last+1 with wrap; the modulo keeps non-power-of-2 counts in range.
    always_comb begin
        pick     = last;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= N_MASTER; i++) begin
            scan_idx = IDX_W'((int'(last) + i) % N_MASTER);
            if (!found && m_cyc_i[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LAST_IDX;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = gnt;
                end else if (gnt_stb && !s_ack_i && !s_err_i) begin
                    // A response in the last allowed wait cycle bypasses this branch and completes normally.
                    if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                        state_nxt = ABORT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ABORT: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!gnt_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = gnt;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        grant_o = '0;
        case (state)
            BUSY: begin
                s_cyc_o      = gnt_cyc;
                s_stb_o      = gnt_stb;
                s_we_o       = m_we_i[gnt];
                s_adr_o      = adr_arr[gnt];
                s_dat_o      = dat_arr[gnt];
                s_sel_o      = sel_arr[gnt];
                m_ack_o[gnt] = s_ack_i;
                m_err_o[gnt] = s_err_i;
                grant_o[gnt] = 1'b1;
            end
            ABORT: begin
                m_err_o[gnt] = 1'b1;
                grant_o[gnt] = 1'b1;
            end
            DRAIN: begin
                grant_o[gnt] = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - scoreboard bench for wb_rr_arbiter (3 masters, TIMEOUT=8)
module tb_wb_rr_arbiter;
    localparam int N = 3;
    localparam logic [31:0] K = 32'h5A5A_0000;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   m_cyc_i = '0;
    logic [N-1:0]   m_stb_i = '0;
    logic [N-1:0]   m_we_i = '0;
    logic [32*N-1:0] m_adr_i = '0;
    logic [32*N-1:0] m_dat_i = '0;
    logic [4*N-1:0] m_sel_i = '0;
    logic [31:0]    m_dat_o;
    logic [N-1:0]   m_ack_o, m_err_o, grant_o;
    logic           s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]    s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]     s_sel_o;
    logic           s_ack_i, s_err_i;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    // Slave model: responds after ack_delay wait cycles; read data is address xor K.
    logic       slave_en = 1'b1;
    logic       slave_err = 1'b0;
    logic       force_ack = 1'b0;
    int         ack_delay = 0;
    logic [7:0] wcnt = '0;
    logic       slave_hit;

    assign slave_hit = slave_en && s_cyc_o && s_stb_o && (wcnt == 8'(ack_delay));
    assign s_ack_i   = force_ack | (slave_hit & ~slave_err);
    assign s_err_i   = slave_hit & slave_err;
    assign s_dat_i   = s_adr_o ^ K;

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && !s_ack_i && !s_err_i) wcnt <= wcnt + 8'd1;
        else wcnt <= '0;
    end

    typedef struct {
        byte          kind;
        logic [N-1:0] val;
        logic [31:0]  adr;
        logic [31:0]  dat;
        int           gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_g(input logic [N-1:0] v, input logic [31:0] a, input logic [31:0] d, input int gap);
        ev_t e;
        e.kind = "G"; e.val = v; e.adr = a; e.dat = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input byte kind, input logic [N-1:0] v, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.val = v; e.adr = data; e.dat = '0; e.gap = -1;
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input ev_t got);
        ev_t want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got %c val=%b adr=%h, want no event", got.kind, got.val, got.adr);
            return;
        end
        want = exp_q.pop_front();
        if (got.kind != want.kind || got.val !== want.val || got.adr !== want.adr ||
            (want.kind == "G" && got.dat !== want.dat) || (want.gap >= 0 && got.gap != want.gap)) begin
            n_bad++;
            $display("FAIL sb_event: got %c val=%b adr=%h dat=%h gap=%0d, want %c val=%b adr=%h dat=%h gap=%0d",
                     got.kind, got.val, got.adr, got.dat, got.gap,
                     want.kind, want.val, want.adr, want.dat, want.gap);
        end
    endtask

    initial begin : monitor
        logic [N-1:0] prev_g;
        int           idle_run;
        ev_t          ev;
        prev_g   = '0;
        idle_run = 1000;
        forever begin
            @(negedge clk);
            if (grant_o != '0 && prev_g == '0) begin
                ev.kind = "G"; ev.val = grant_o; ev.adr = s_adr_o; ev.dat = s_dat_o; ev.gap = idle_run;
                sb_compare(ev);
            end
            if (m_ack_o != '0) begin
                ev.kind = "A"; ev.val = m_ack_o; ev.adr = m_dat_o; ev.dat = '0; ev.gap = -1;
                sb_compare(ev);
            end
            if (m_err_o != '0) begin
                ev.kind = "E"; ev.val = m_err_o; ev.adr = m_dat_o; ev.dat = '0; ev.gap = -1;
                sb_compare(ev);
            end
            if (grant_o == '0) idle_run++;
            else idle_run = 0;
            prev_g = grant_o;
        end
    end

    task automatic drive(input int k, input logic [31:0] adr, input logic [31:0] dat, input logic we);
        m_adr_i[32*k +: 32] = adr;
        m_dat_i[32*k +: 32] = dat;
        m_sel_i[4*k +: 4]   = 4'hF;
        m_we_i[k]           = we;
        m_cyc_i[k]          = 1'b1;
        m_stb_i[k]          = 1'b1;
    endtask

    task automatic drop(input int k);
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input string name);
        int t;
        bit got;
        t = 0;
        got = 1'b0;
        while (!got && t < 80) begin
            @(negedge clk);
            t++;
            if (m_ack_o[k] || m_err_o[k]) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no response for master %0d in 80 cycles, want ack/err", name, k);
        end
    endtask

    task automatic xfer(input int k, input int nb, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input string name);
        drive(k, adr, dat, we);
        for (int b = 0; b < nb; b++) begin
            wait_resp(k, name);
            @(posedge clk);
            #1;
            if (b + 1 < nb) drive(k, adr + 32'(4 * (b + 1)), dat + 32'(b + 1), we);
        end
        drop(k);
    endtask

    function automatic logic [31:0] rr_adr(input int k, input int it);
        return 32'h2000_0000 + 32'(k * 256 + it * 16);
    endfunction

    function automatic logic [31:0] rr_dat(input int k, input int it);
        return 32'hC0DE_0000 + 32'(k * 16 + it);
    endfunction

    task automatic rr_master(input int k);
        for (int it = 0; it < 2; it++) begin
            xfer(k, 1, rr_adr(k, it), rr_dat(k, it), 1'b1, "rr");
            if (it == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : global_limit
        #100000;
        $display("FAIL global_timeout: got no finish by 100000, want finish");
        $fatal(1);
    end

    initial begin : stimulus
        int  sc, tt;
        bit  done;
        bit  got;

        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_grant", grant_o, 0);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_s_stb", s_stb_o, 0);
        check("rst_s_adr", s_adr_o, 0);
        check("rst_m_ack", m_ack_o, 0);
        check("rst_m_err", m_err_o, 0);
        @(posedge clk);
        #1;

        // Round robin: all three request continuously, order 0,1,2,0,1,2 with one idle cycle between grants.
        for (int it = 0; it < 2; it++) begin
            for (int k = 0; k < N; k++) begin
                push_g(3'(1 << k), rr_adr(k, it), rr_dat(k, it), (it == 0 && k == 0) ? -1 : 1);
                push_r("A", 3'(1 << k), rr_adr(k, it) ^ K);
            end
        end
        fork
            rr_master(0);
            rr_master(1);
            rr_master(2);
        join

        // Burst lock: master 0 holds cyc for 4 beats while master 1 waits.
        settle();
        push_g(3'b001, 32'h3000_0000, 32'h1111_0000, -1);
        for (int b = 0; b < 4; b++) push_r("A", 3'b001, (32'h3000_0000 + 32'(4 * b)) ^ K);
        push_g(3'b010, 32'h3000_0100, 32'h2222_0000, 1);
        push_r("A", 3'b010, 32'h3000_0100 ^ K);
        fork
            xfer(0, 4, 32'h3000_0000, 32'h1111_0000, 1'b0, "burst_m0");
            xfer(1, 1, 32'h3000_0100, 32'h2222_0000, 1'b0, "burst_m1");
        join

        // Single request latency, slave acks after 2 wait cycles.
        settle();
        ack_delay = 2;
        push_g(3'b010, 32'h1000_0040, 32'hDEAD_BEEF, -1);
        push_r("A", 3'b010, 32'h1000_0040 ^ K);
        fork
            xfer(1, 1, 32'h1000_0040, 32'hDEAD_BEEF, 1'b1, "single");
            begin
                @(negedge clk);
                check("lat_grant_idle", grant_o, 0);
                @(negedge clk);
                check("lat_grant", grant_o, 3'b010);
                check("lat_s_cyc", s_cyc_o, 1);
                check("lat_s_adr", s_adr_o, 32'h1000_0040);
                check("lat_s_dat", s_dat_o, 32'hDEAD_BEEF);
                check("lat_s_sel", s_sel_o, 4'hF);
                check("lat_s_we", s_we_o, 1);
                @(negedge clk);
                check("lat_no_early_ack", m_ack_o, 0);
                @(negedge clk);
                check("lat_s_ack", s_ack_i, 1);
                check("lat_m_ack", m_ack_o, 3'b010);
            end
        join

        // Slave error is routed to the granted master.
        settle();
        ack_delay = 0;
        slave_err = 1'b1;
        push_g(3'b001, 32'h4000_0000, 32'h4444_0000, -1);
        push_r("E", 3'b001, 32'h4000_0000 ^ K);
        xfer(0, 1, 32'h4000_0000, 32'h4444_0000, 1'b0, "slave_err");
        slave_err = 1'b0;

        // Watchdog: slave never responds.
        settle();
        slave_en = 1'b0;
        push_g(3'b010, 32'h5000_0000, 32'h5555_0000, -1);
        push_r("E", 3'b010, K);
        drive(1, 32'h5000_0000, 32'h5555_0000, 1'b0);
        sc = 0; tt = 0; got = 1'b0;
        while (!got && tt < 40) begin
            @(negedge clk);
            tt++;
            if (m_err_o != '0) got = 1'b1;
            else if (s_stb_o) sc++;
        end
        check("wd_abort_seen", got, 1);
        check("wd_stb_cycles", sc, 8);
        check("wd_abort_err", m_err_o, 3'b010);
        check("wd_abort_s_cyc", s_cyc_o, 0);
        check("wd_abort_s_stb", s_stb_o, 0);
        @(posedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        check("drain_late_ack", m_ack_o, 0);
        check("drain_err", m_err_o, 0);
        check("drain_s_cyc", s_cyc_o, 0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        drop(1);
        @(negedge clk);
        @(negedge clk);
        check("drain_to_idle", grant_o, 0);
        slave_en = 1'b1;

        // Watchdog edge: ack in the 8th wait cycle is a normal completion.
        settle();
        ack_delay = 7;
        push_g(3'b010, 32'h5000_0080, 32'h6666_0000, -1);
        push_r("A", 3'b010, 32'h5000_0080 ^ K);
        fork
            xfer(1, 1, 32'h5000_0080, 32'h6666_0000, 1'b0, "wd_edge");
            begin
                sc = 0; tt = 0; done = 1'b0;
                while (!done && tt < 40) begin
                    @(negedge clk);
                    tt++;
                    if (s_stb_o) sc++;
                    if (m_ack_o != '0 || m_err_o != '0) done = 1'b1;
                end
                check("edge_done", done, 1);
                check("edge_stb_cycles", sc, 8);
                check("edge_ack", m_ack_o, 3'b010);
                check("edge_no_err", m_err_o, 0);
            end
        join

        // Reset while master 2 is mid-transfer; master 0 must win afterwards.
        settle();
        ack_delay = 0;
        slave_en = 1'b0;
        push_g(3'b100, 32'h6000_0000, 32'h7777_0000, -1);
        drive(2, 32'h6000_0000, 32'h7777_0000, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_pre_grant", grant_o, 3'b100);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        slave_en = 1'b1;
        push_g(3'b001, 32'h7000_0000, 32'h8888_0000, 1);
        push_r("A", 3'b001, 32'h7000_0000 ^ K);
        push_g(3'b100, 32'h6000_0000, 32'h7777_0000, 1);
        push_r("A", 3'b100, 32'h6000_0000 ^ K);
        fork
            xfer(0, 1, 32'h7000_0000, 32'h8888_0000, 1'b0, "rst_m0");
            begin
                @(negedge clk);
                check("mid_rst_grant", grant_o, 0);
                check("mid_rst_s_cyc", s_cyc_o, 0);
                check("mid_rst_s_stb", s_stb_o, 0);
                check("mid_rst_m_ack", m_ack_o, 0);
                check("mid_rst_m_err", m_err_o, 0);
            end
            begin
                wait_resp(2, "rst_m2");
                @(posedge clk);
                #1 drop(2);
            end
        join

        settle();
        repeat (3) @(posedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
